// File: rtl/lift_pkg.sv
// Package shared by the lift call scheduler slice.
// Holds the FSM state type, default parameter values and a small width helper.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } lift_state_e;

  localparam int N_FLOORS_DEF   = 8;
  localparam int FLOOR_W_DEF    = 3;
  localparam int HOME_FLOOR_DEF = 1;
  localparam int TRAVEL_CYC_DEF = 4;
  localparam int DOOR_CYC_DEF   = 3;

  // Counter width able to hold 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage : lift_pkg

// File: rtl/lift_call_scheduler_if.sv
// Button-side and status-side signals of the lift call scheduler.
//   hall_req / car_req : per-floor call inputs (level or pulse)
//   floor_o            : current car floor
//   dir_up_o           : 1 = travelling / last travelled up
//   moving_o           : car is between floors
//   door_open_o        : door is open
//   busy_o             : FSM not idle or calls pending
//   pending_o          : latched, not yet served calls
// master = button/display side, slave = scheduler.
interface lift_call_scheduler_if #(
  parameter int N_FLOORS = lift_pkg::N_FLOORS_DEF,
  parameter int FLOOR_W  = lift_pkg::FLOOR_W_DEF
);

  logic [N_FLOORS-1:0] hall_req;
  logic [N_FLOORS-1:0] car_req;
  logic [FLOOR_W-1:0]  floor_o;
  logic                dir_up_o;
  logic                moving_o;
  logic                door_open_o;
  logic                busy_o;
  logic [N_FLOORS-1:0] pending_o;

  modport master (
    output hall_req, car_req,
    input  floor_o, dir_up_o, moving_o, door_open_o, busy_o, pending_o
  );

  modport slave (
    input  hall_req, car_req,
    output floor_o, dir_up_o, moving_o, door_open_o, busy_o, pending_o
  );

endinterface : lift_call_scheduler_if

// File: rtl/lift_req_tracker.sv
// Pending-call register for the lift scheduler.
// OR-latches hall and cabin calls, clears the bit of the current floor while
// the door is open (clear beats a simultaneous new call), and derives the
// here / above / below flags from the registered pending vector.
//   clk, rst   : clock, synchronous active-high reset
//   hall_req   : hall calls per floor
//   car_req    : cabin calls per floor
//   clr_en     : door open this cycle -> absorb call at floor_i
//   floor_i    : current car floor
//   pending_o  : registered pending calls
//   here_o     : call pending at floor_i
//   above_o    : call pending at a floor above floor_i
//   below_o    : call pending at a floor below floor_i
module lift_req_tracker #(
  parameter int N_FLOORS = lift_pkg::N_FLOORS_DEF,
  parameter int FLOOR_W  = lift_pkg::FLOOR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] hall_req,
  input  logic [N_FLOORS-1:0] car_req,
  input  logic                clr_en,
  input  logic [FLOOR_W-1:0]  floor_i,
  output logic [N_FLOORS-1:0] pending_o,
  output logic                here_o,
  output logic                above_o,
  output logic                below_o
);

  logic [N_FLOORS-1:0] pending_q;
  logic [N_FLOORS-1:0] pending_d;
  logic [N_FLOORS-1:0] clr;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    clr = '0;
    if (clr_en) clr[floor_i] = 1'b1;
    pending_d = (pending_q | hall_req | car_req) & ~clr;
  end

  // NOTE: this vector is reset because a reset must drop every call; it is
  // a handful of flops, not a memory array.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    above_o = 1'b0;
    below_o = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) > floor_i)) above_o = 1'b1;
      if (pending_q[i] && (FLOOR_W'(i) < floor_i)) below_o = 1'b1;
    end
  end

  assign here_o    = pending_q[floor_i];
  assign pending_o = pending_q;

endmodule : lift_req_tracker

// File: rtl/lift_call_scheduler.sv
// Single-car lift scheduler (SCAN policy).
// Keeps travelling in the current direction while calls lie ahead, reverses
// otherwise, steps one floor every TRAVEL_CYC cycles and holds the door open
// for DOOR_CYC cycles at each served floor.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : lift_call_scheduler_if.slave (call inputs, floor/status outputs)
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int N_FLOORS   = N_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF,
  parameter int HOME_FLOOR = HOME_FLOOR_DEF,
  parameter int TRAVEL_CYC = TRAVEL_CYC_DEF,
  parameter int DOOR_CYC   = DOOR_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  lift_call_scheduler_if.slave  bus
);

  localparam int TRAVEL_W = cnt_width(TRAVEL_CYC);
  localparam int DOOR_W   = cnt_width(DOOR_CYC);

  localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYC - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYC - 1);

  lift_state_e         state_q,      state_d;
  logic [FLOOR_W-1:0]  floor_q,      floor_d;
  logic                dir_up_q,     dir_up_d;
  logic [TRAVEL_W-1:0] travel_cnt_q, travel_cnt_d;
  logic [DOOR_W-1:0]   door_cnt_q,   door_cnt_d;

  logic [N_FLOORS-1:0] pending;
  logic                here;
  logic                above;
  logic                below;
  logic                ahead;
  logic                behind;

  lift_req_tracker #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_req_tracker (
    .clk       (clk),
    .rst       (rst),
    .hall_req  (bus.hall_req),
    .car_req   (bus.car_req),
    .clr_en    (state_q == DOOR),
    .floor_i   (floor_q),
    .pending_o (pending),
    .here_o    (here),
    .above_o   (above),
    .below_o   (below)
  );

  // Calls relative to the current direction of travel.
  assign ahead  = dir_up_q ? above : below;
  assign behind = dir_up_q ? below : above;

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d    = DOOR;
          door_cnt_d = DOOR_LOAD;
        end else if (above && (dir_up_q || !below)) begin
          state_d      = MOVE;
          dir_up_d     = 1'b1;
          travel_cnt_d = TRAVEL_LOAD;
        end else if (below) begin
          state_d      = MOVE;
          dir_up_d     = 1'b0;
          travel_cnt_d = TRAVEL_LOAD;
        end
      end

      MOVE: begin
        if (travel_cnt_q == '0) begin
          // A move is only ever started toward a pending call, and calls are
          // cleared only in DOOR, so the step stays inside 0..N_FLOORS-1.
          floor_d      = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          travel_cnt_d = TRAVEL_LOAD;
          if (pending[floor_d]) begin
            state_d    = DOOR;
            door_cnt_d = DOOR_LOAD;
          end
        end else begin
          travel_cnt_d = travel_cnt_q - TRAVEL_W'(1);
        end
      end

      DOOR: begin
        // Timer is loaded once on entry; calls at this floor do not extend it.
        if (door_cnt_q == '0) begin
          if (ahead) begin
            state_d      = MOVE;
            travel_cnt_d = TRAVEL_LOAD;
          end else if (behind) begin
            state_d      = MOVE;
            dir_up_d     = ~dir_up_q;
            travel_cnt_d = TRAVEL_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          door_cnt_d = door_cnt_q - DOOR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      floor_q      <= FLOOR_W'(HOME_FLOOR);
      dir_up_q     <= 1'b1;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_up_q     <= dir_up_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
    end
  end

  floor_in_range_a : assert property (
    @(posedge clk) disable iff (rst) int'(floor_q) < N_FLOORS
  );

  assign bus.floor_o     = floor_q;
  assign bus.dir_up_o    = dir_up_q;
  assign bus.moving_o    = (state_q == MOVE);
  assign bus.door_open_o = (state_q == DOOR);
  assign bus.busy_o      = (state_q != IDLE) || (|pending);
  assign bus.pending_o   = pending;

endmodule : lift_call_scheduler

// File: tb/tb_lift_call_scheduler.sv
// Directed self-checking bench for lift_call_scheduler
// (N_FLOORS=8, HOME_FLOOR=1, TRAVEL_CYC=4, DOOR_CYC=3).
// Edge numbers in comments count rising edges from the cycle a call is driven;
// outputs are sampled 1 time unit after each rising edge.
module tb_lift_call_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  lift_call_scheduler_if #(.N_FLOORS(8), .FLOOR_W(3)) bus ();

  lift_call_scheduler #(
    .N_FLOORS   (8),
    .FLOOR_W    (3),
    .HOME_FLOOR (1),
    .TRAVEL_CYC (4),
    .DOOR_CYC   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input int fl, input bit up, input bit mv,
                        input bit dr, input bit bz, input logic [7:0] pend);
    check({tag, ".floor"},   32'(bus.floor_o),     32'(fl));
    check({tag, ".dir_up"},  32'(bus.dir_up_o),    32'(up));
    check({tag, ".moving"},  32'(bus.moving_o),    32'(mv));
    check({tag, ".door"},    32'(bus.door_open_o), 32'(dr));
    check({tag, ".busy"},    32'(bus.busy_o),      32'(bz));
    check({tag, ".pending"}, 32'(bus.pending_o),   32'(pend));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    bus.hall_req = '0;
    bus.car_req  = '0;
    tick(2);
    status("reset", 1, 1, 0, 0, 0, 8'h00);
    rst = 1'b0;

    // Reset mid-MOVE at floor 3: head for 6, floor 3 reached at E9.
    bus.car_req = 8'h40;
    tick(1);                                   // E0
    bus.car_req = '0;
    tick(10);                                  // E10
    status("t1.pre", 3, 1, 1, 0, 1, 8'h40);
    rst = 1'b1;
    tick(1);
    status("t1.rst", 1, 1, 0, 0, 0, 8'h00);
    rst = 1'b0;

    // One-cycle cabin call to floor 5 from idle floor 1.
    bus.car_req = 8'h20;
    tick(1);                                   // E0: latched
    bus.car_req = '0;
    status("t2.latch", 1, 1, 0, 0, 1, 8'h20);
    tick(1);                                   // E1: MOVE
    status("t2.go", 1, 1, 1, 0, 1, 8'h20);
    tick(3);                                   // E4
    check("t2.e4.floor", 32'(bus.floor_o), 1);
    tick(1);                                   // E5
    check("t2.e5.floor", 32'(bus.floor_o), 2);
    tick(4);                                   // E9
    check("t2.e9.floor", 32'(bus.floor_o), 3);
    tick(4);                                   // E13
    check("t2.e13.floor", 32'(bus.floor_o), 4);
    tick(4);                                   // E17: arrive, door opens
    status("t2.arrive", 5, 1, 0, 1, 1, 8'h20);
    tick(2);                                   // E19: third door cycle
    status("t2.door3", 5, 1, 0, 1, 1, 8'h00);
    tick(1);                                   // E20: idle
    status("t2.idle", 5, 1, 0, 0, 0, 8'h00);

    // Hall calls 3, 6, 0 together from floor 1.
    do_reset();
    bus.hall_req = 8'h49;
    tick(1);                                   // E0
    bus.hall_req = '0;
    check("t3.latch", 32'(bus.pending_o), 32'h49);
    tick(9);                                   // E9: door at 3
    status("t3.at3", 3, 1, 0, 1, 1, 8'h49);
    tick(3);                                   // E12: continue up
    status("t3.leave3", 3, 1, 1, 0, 1, 8'h41);
    tick(12);                                  // E24: door at 6
    status("t3.at6", 6, 1, 0, 1, 1, 8'h41);
    tick(3);                                   // E27: reverse
    status("t3.rev", 6, 0, 1, 0, 1, 8'h01);
    tick(24);                                  // E51: door at 0
    status("t3.at0", 0, 0, 0, 1, 1, 8'h01);
    tick(3);                                   // E54: idle
    status("t3.idle", 0, 0, 0, 0, 0, 8'h00);

    // Cabin call at the idle floor: door only, no movement.
    do_reset();
    bus.car_req = 8'h02;
    tick(1);                                   // E0
    bus.car_req = '0;
    for (int i = 1; i <= 3; i++) begin
      tick(1);                                 // E1..E3
      check("t4.door", 32'(bus.door_open_o), 1);
      check("t4.moving", 32'(bus.moving_o), 0);
      check("t4.floor", 32'(bus.floor_o), 1);
    end
    tick(1);                                   // E4
    status("t4.idle", 1, 1, 0, 0, 0, 8'h00);

    // 1 -> 6 with hall call 4 entered while at floor 2; at 4 the hall
    // button is held for the whole door period.
    do_reset();
    bus.car_req = 8'h40;
    tick(1);                                   // E0
    bus.car_req = '0;
    tick(5);                                   // E5: floor 2
    check("t5.at2", 32'(bus.floor_o), 2);
    bus.hall_req = 8'h10;
    tick(1);                                   // E6
    bus.hall_req = '0;
    check("t5.latch", 32'(bus.pending_o), 32'h50);
    tick(7);                                   // E13: stop at 4
    status("t5.at4", 4, 1, 0, 1, 1, 8'h50);
    bus.hall_req = 8'h10;
    tick(2);                                   // E15: third door cycle
    status("t6.door3", 4, 1, 0, 1, 1, 8'h40);
    tick(1);                                   // E16: door closes anyway
    bus.hall_req = '0;
    status("t6.closed", 4, 1, 1, 0, 1, 8'h40);
    tick(8);                                   // E24: door at 6
    status("t5.at6", 6, 1, 0, 1, 1, 8'h40);
    tick(3);                                   // E27: idle
    status("t5.idle", 6, 1, 0, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_lift_call_scheduler
